// File: rtl/gcm_ctrl.sv
// gcm_ctrl: sequencer for one AES-GCM message. Derives H and E(K,J0), steps the
// GCTR and GHASH engines block by block, hashes the length block and emits the
// tag. Owns the single AES core and lends it to GCTR outside the key-setup states.
module gcm_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [95:0]        iv,
   input  logic               dec,
   input  logic               no_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_blk,
   input  logic               in_is_aad,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       out_blk,
   output logic [127:0]       tag,
   output logic               done,
   output logic               error,
   output logic               busy,
   output logic               gctr_en,
   output logic [127:0]       gctr_icb,
   output logic [127:0]       gctr_data_blk,
   input  logic [127:0]       gctr_out_blk,
   input  logic               gctr_done,
   input  logic [127:0]       gctr_aes_in_blk,
   input  logic               gctr_aes_start,
   output logic [127:0]       gctr_aes_out_blk,
   output logic               gctr_aes_done,
   output logic [127:0]       aes_in_blk,
   output logic               aes_start,
   input  logic [127:0]       aes_out_blk,
   input  logic               aes_done,
   output logic               ghash_en,
   output logic [127:0]       ghash_g_prev,
   output logic [127:0]       ghash_data_blk,
   output logic [127:0]       ghash_subkey_H,
   input  logic [127:0]       ghash_result,
   input  logic               ghash_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_H_GEN, S_J0_ENC, S_WAIT_IN, S_AAD_HASH,
      S_CTR, S_OUT_HASH, S_LEN_HASH, S_FINISH
   } state_e;

   // Counter block increment: only the low 32 bits count, wrapping without carry.
   function automatic logic [127:0] inc32(input logic [127:0] x);
      return {x[127:32], x[31:0] + 32'd1};
   endfunction

   state_e             state_q, state_d;
   logic               first_q, first_d;     // high on the first cycle of each state
   logic [95:0]        iv_q, iv_d;
   logic               dec_q, dec_d;
   logic               no_data_q, no_data_d;
   logic [127:0]       h_q, h_d;
   logic [127:0]       ej0_q, ej0_d;
   logic [127:0]       icb_q, icb_d;
   logic [127:0]       s_q, s_d;
   logic [CNT_W-1:0]   aad_cnt_q, aad_cnt_d;
   logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
   logic               pay_seen_q, pay_seen_d;
   logic [127:0]       blk_q, blk_d;
   logic               last_q, last_d;
   logic [127:0]       out_blk_q, out_blk_d;
   logic               out_ack_q, out_ack_d;
   logic               gh_ack_q, gh_ack_d;
   logic [127:0]       tag_q, tag_d;
   logic               done_q, done_d;

   logic               own_aes;
   logic               aes_req;
   logic [127:0]       aes_req_blk;
   logic               out_hs;
   logic [63:0]        aad_bits, pay_bits;
   logic [127:0]       j0;

   assign j0       = {iv_q, 32'h0000_0001};
   assign aad_bits = 64'(aad_cnt_q) << 7;
   assign pay_bits = 64'(pay_cnt_q) << 7;

   // Next-state and output decode.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d     = state_q;
      iv_d        = iv_q;
      dec_d       = dec_q;
      no_data_d   = no_data_q;
      h_d         = h_q;
      ej0_d       = ej0_q;
      icb_d       = icb_q;
      s_d         = s_q;
      aad_cnt_d   = aad_cnt_q;
      pay_cnt_d   = pay_cnt_q;
      pay_seen_d  = pay_seen_q;
      blk_d       = blk_q;
      last_d      = last_q;
      out_blk_d   = out_blk_q;
      out_ack_d   = out_ack_q;
      gh_ack_d    = gh_ack_q;
      tag_d       = tag_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      error       = 1'b0;
      aes_req     = 1'b0;
      aes_req_blk = '0;
      gctr_en     = 1'b0;
      ghash_en    = 1'b0;
      ghash_data_blk = '0;
      out_hs      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               iv_d       = iv;
               dec_d      = dec;
               no_data_d  = no_data;
               s_d        = '0;
               aad_cnt_d  = '0;
               pay_cnt_d  = '0;
               pay_seen_d = 1'b0;
               state_d    = S_H_GEN;
            end
         end
         S_H_GEN: begin
            aes_req = first_q;
            if (aes_done) begin
               h_d     = aes_out_blk;
               state_d = S_J0_ENC;
            end
         end
         S_J0_ENC: begin
            aes_req     = first_q;
            aes_req_blk = j0;
            if (aes_done) begin
               ej0_d   = aes_out_blk;
               icb_d   = inc32(j0);
               state_d = no_data_q ? S_LEN_HASH : S_WAIT_IN;
            end
         end
         S_WAIT_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // AAD after payload is a protocol violation: flag it and drop the block.
               if (in_is_aad && pay_seen_q) begin
                  error = 1'b1;
               end else begin
                  blk_d  = in_blk;
                  last_d = in_last;
                  if (in_is_aad) begin
                     aad_cnt_d = aad_cnt_q + CNT_W'(1);
                     state_d   = S_AAD_HASH;
                  end else begin
                     pay_cnt_d  = pay_cnt_q + CNT_W'(1);
                     pay_seen_d = 1'b1;
                     state_d    = S_CTR;
                  end
               end
            end
         end
         S_AAD_HASH: begin
            ghash_en       = first_q;
            ghash_data_blk = blk_q;
            if (ghash_done) begin
               s_d     = ghash_result;
               state_d = last_q ? S_LEN_HASH : S_WAIT_IN;
            end
         end
         S_CTR: begin
            gctr_en = first_q;
            if (gctr_done) begin
               out_blk_d = gctr_out_blk;
               icb_d     = inc32(icb_q);
               out_ack_d = 1'b0;
               gh_ack_d  = 1'b0;
               state_d   = S_OUT_HASH;
            end
         end
         S_OUT_HASH: begin
            // Output handshake and GHASH completion may arrive in either order.
            out_valid      = !out_ack_q;
            out_hs         = !out_ack_q && out_ready;
            ghash_en       = first_q;
            ghash_data_blk = dec_q ? blk_q : out_blk_q;
            out_ack_d      = out_ack_q || out_hs;
            gh_ack_d       = gh_ack_q || ghash_done;
            if (ghash_done) s_d = ghash_result;
            if (out_ack_d && gh_ack_d) state_d = last_q ? S_LEN_HASH : S_WAIT_IN;
         end
         S_LEN_HASH: begin
            ghash_en       = first_q;
            ghash_data_blk = {aad_bits, pay_bits};
            if (ghash_done) begin
               s_d     = ghash_result;
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            tag_d   = s_q ^ ej0_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      done_d  = (state_q == S_FINISH);
      first_d = (state_d != state_q);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: datapath registers are cleared too, so an aborted message leaves no key material behind.
      if (!reset_n) begin
         state_q    <= S_IDLE;
         first_q    <= 1'b0;
         iv_q       <= '0;
         dec_q      <= 1'b0;
         no_data_q  <= 1'b0;
         h_q        <= '0;
         ej0_q      <= '0;
         icb_q      <= '0;
         s_q        <= '0;
         aad_cnt_q  <= '0;
         pay_cnt_q  <= '0;
         pay_seen_q <= 1'b0;
         blk_q      <= '0;
         last_q     <= 1'b0;
         out_blk_q  <= '0;
         out_ack_q  <= 1'b0;
         gh_ack_q   <= 1'b0;
         tag_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         first_q    <= first_d;
         iv_q       <= iv_d;
         dec_q      <= dec_d;
         no_data_q  <= no_data_d;
         h_q        <= h_d;
         ej0_q      <= ej0_d;
         icb_q      <= icb_d;
         s_q        <= s_d;
         aad_cnt_q  <= aad_cnt_d;
         pay_cnt_q  <= pay_cnt_d;
         pay_seen_q <= pay_seen_d;
         blk_q      <= blk_d;
         last_q     <= last_d;
         out_blk_q  <= out_blk_d;
         out_ack_q  <= out_ack_d;
         gh_ack_q   <= gh_ack_d;
         tag_q      <= tag_d;
         done_q     <= done_d;
      end
   end

   // AES core sharing: the controller owns it only while deriving H and E(K,J0).
   assign own_aes          = (state_q == S_H_GEN) || (state_q == S_J0_ENC);
   assign aes_start        = own_aes ? aes_req : gctr_aes_start;
   assign aes_in_blk       = own_aes ? aes_req_blk : gctr_aes_in_blk;
   assign gctr_aes_done    = own_aes ? 1'b0 : aes_done;
   assign gctr_aes_out_blk = aes_out_blk;

   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign tag            = tag_q;
   assign out_blk        = out_blk_q;
   assign gctr_icb       = icb_q;
   assign gctr_data_blk  = blk_q;
   assign ghash_g_prev   = s_q;
   assign ghash_subkey_H = h_q;

endmodule

// File: tb/tb_gcm_ctrl.sv
// tb_gcm_ctrl: directed bench for gcm_ctrl. Small behavioural models stand in
// for the AES core, GCTR and GHASH; expected tags come from a bench-side GF(2^128)
// multiply and known AES-128 outputs under the all-zero key.
module tb_gcm_ctrl;

   localparam int TMO     = 300;
   localparam int AES_LAT = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [95:0]   iv = '0;
   logic          dec = 1'b0;
   logic          no_data = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_blk = '0;
   logic          in_is_aad = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  out_blk, tag;
   logic          done, error, busy;
   logic          gctr_en;
   logic [127:0]  gctr_icb, gctr_data_blk, gctr_out_blk;
   logic          gctr_done;
   logic [127:0]  gctr_aes_in_blk, gctr_aes_out_blk;
   logic          gctr_aes_start, gctr_aes_done;
   logic [127:0]  aes_in_blk, aes_out_blk;
   logic          aes_start, aes_done;
   logic          ghash_en;
   logic [127:0]  ghash_g_prev, ghash_data_blk, ghash_subkey_H, ghash_result;
   logic          ghash_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int gh_lat = 2;
   int gh_cyc = 0;
   int done_cnt = 0, err_cnt = 0, rdy_cnt = 0;
   logic [127:0] icb_seen[$];

   always #5 clk = ~clk;

   gcm_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .iv(iv), .dec(dec), .no_data(no_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_blk(in_blk), .in_is_aad(in_is_aad),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk),
      .tag(tag), .done(done), .error(error), .busy(busy),
      .gctr_en(gctr_en), .gctr_icb(gctr_icb), .gctr_data_blk(gctr_data_blk),
      .gctr_out_blk(gctr_out_blk), .gctr_done(gctr_done),
      .gctr_aes_in_blk(gctr_aes_in_blk), .gctr_aes_start(gctr_aes_start),
      .gctr_aes_out_blk(gctr_aes_out_blk), .gctr_aes_done(gctr_aes_done),
      .aes_in_blk(aes_in_blk), .aes_start(aes_start), .aes_out_blk(aes_out_blk),
      .aes_done(aes_done), .ghash_en(ghash_en), .ghash_g_prev(ghash_g_prev),
      .ghash_data_blk(ghash_data_blk), .ghash_subkey_H(ghash_subkey_H),
      .ghash_result(ghash_result), .ghash_done(ghash_done)
   );

   // Known AES-128 outputs for the all-zero key; other inputs get a stand-in permutation.
   function automatic logic [127:0] aes_model(input logic [127:0] x);
      case (x)
         128'h0:  return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
         128'h1:  return 128'h58e2fccefa7e3061367f1d57a4e7455a;
         128'h2:  return 128'h0388dace60b6a392f328c2b971b2fe78;
         default: return {x[95:0], x[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      endcase
   endfunction

   // GF(2^128) multiply, bit 127 is the x^0 coefficient.
   function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
      logic [127:0] z = '0;
      logic [127:0] v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   function automatic logic [127:0] icb_at(input int i);
      if (i < icb_seen.size()) return icb_seen[i];
      return '1;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Cycle counter, advanced on the active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (done)     done_cnt <= done_cnt + 1;
      if (error)    err_cnt  <= err_cnt + 1;
      if (in_ready) rdy_cnt  <= rdy_cnt + 1;
   end

   // AES core model: fixed latency.
   int           aes_cnt;
   logic [127:0] aes_hold;
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aes_cnt <= 0; aes_done <= 1'b0; aes_out_blk <= '0; aes_hold <= '0;
      end else begin
         aes_done <= 1'b0;
         if (aes_cnt == 1) begin
            aes_done <= 1'b1; aes_out_blk <= aes_model(aes_hold); aes_cnt <= 0;
         end else if (aes_cnt > 1) begin
            aes_cnt <= aes_cnt - 1;
         end else if (aes_start) begin
            aes_hold <= aes_in_blk; aes_cnt <= AES_LAT;
         end
      end
   end

   // GCTR model: borrows the AES core through the controller, XORs the keystream.
   int           gc_ph;
   logic [127:0] gc_icb, gc_data;
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gc_ph <= 0; gctr_done <= 1'b0; gctr_out_blk <= '0;
         gctr_aes_start <= 1'b0; gctr_aes_in_blk <= '0; gc_icb <= '0; gc_data <= '0;
      end else begin
         gctr_done      <= 1'b0;
         gctr_aes_start <= 1'b0;
         case (gc_ph)
            0: if (gctr_en) begin
                  gc_icb <= gctr_icb; gc_data <= gctr_data_blk;
                  icb_seen.push_back(gctr_icb); gc_ph <= 1;
               end
            1: begin gctr_aes_start <= 1'b1; gctr_aes_in_blk <= gc_icb; gc_ph <= 2; end
            2: if (gctr_aes_done) begin
                  gctr_out_blk <= gctr_aes_out_blk ^ gc_data; gctr_done <= 1'b1; gc_ph <= 0;
               end
            default: gc_ph <= 0;
         endcase
      end
   end

   // GHASH model: one multiply step with programmable latency.
   int           gh_cnt;
   logic [127:0] gh_x, gh_h;
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gh_cnt <= 0; ghash_done <= 1'b0; ghash_result <= '0; gh_x <= '0; gh_h <= '0;
      end else begin
         ghash_done <= 1'b0;
         if (gh_cnt == 1) begin
            ghash_done <= 1'b1; ghash_result <= gf_mult(gh_x, gh_h); gh_cnt <= 0; gh_cyc <= cyc;
         end else if (gh_cnt > 1) begin
            gh_cnt <= gh_cnt - 1;
         end else if (ghash_en) begin
            gh_x <= ghash_g_prev ^ ghash_data_blk; gh_h <= ghash_subkey_H; gh_cnt <= gh_lat;
         end
      end
   end

   task automatic do_start(input logic [95:0] v, input logic d, input logic nd);
      @(posedge clk); #1;
      iv = v; dec = d; no_data = nd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_blk(input logic [127:0] b, input logic aad, input logic last);
      int n = 0;
      @(posedge clk); #1;
      in_blk = b; in_is_aad = aad; in_last = last; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check("in_ready_timeout", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic take_out(input logic [127:0] exp, input string name);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < TMO) begin @(negedge clk); n++; end
      check({name, "_valid"}, 128'(out_valid), 128'd1);
      check(name, out_blk, exp);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic wait_done(input logic [127:0] exp, input string name);
      int n = 0;
      @(negedge clk);
      while (!done && n < TMO) begin @(negedge clk); n++; end
      check({name, "_done"}, 128'(done), 128'd1);
      check(name, tag, exp);
      check({name, "_lat"}, 128'(cyc - gh_cyc), 128'd2);
   endtask

   initial begin
      logic [127:0] h_e, s_e, c_e, p_e, a_e, first_out;
      logic [95:0]  iv_e;
      logic         stable;
      int           ib, d0, r0, e0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_ctl", 128'({busy, out_valid, in_ready, done, error, gctr_en, ghash_en, aes_start}), 128'd0);
      check("rst_tag", tag, '0);
      check("rst_out_blk", out_blk, '0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: empty message, tag = E(K,J0)
      r0 = rdy_cnt; d0 = done_cnt;
      do_start(96'h0, 1'b0, 1'b1);
      wait_done(128'h58e2fccefa7e3061367f1d57a4e7455a, "t1_tag");
      @(negedge clk);
      check("t1_no_ready", 128'(rdy_cnt - r0), 128'd0);
      check("t1_one_done", 128'(done_cnt - d0), 128'd1);

      // 2: one zero payload block, encrypt
      gh_lat = 2; ib = icb_seen.size();
      do_start(96'h0, 1'b0, 1'b0);
      send_blk(128'h0, 1'b0, 1'b1);
      take_out(128'h0388dace60b6a392f328c2b971b2fe78, "t2_out");
      wait_done(128'hab6e47d42cec13bdf53a67b21257bddf, "t2_tag");
      check("t2_H", ghash_subkey_H, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      check("t2_icb", icb_at(ib), 128'h2);

      // 3: decrypt the same block, GHASH slower than the output handshake
      gh_lat = 10;
      do_start(96'h0, 1'b1, 1'b0);
      send_blk(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, 1'b1);
      take_out(128'h0, "t3_out");
      wait_done(128'hab6e47d42cec13bdf53a67b21257bddf, "t3_tag");

      // 4: all-ones IV, AAD plus three payload blocks; counter must not carry into the IV
      gh_lat = 3; ib = icb_seen.size();
      iv_e = '1;
      do_start(iv_e, 1'b0, 1'b0);
      h_e = aes_model('0);
      a_e = 128'h00112233445566778899aabbccddeeff;
      send_blk(a_e, 1'b1, 1'b0);
      s_e = gf_mult(a_e, h_e);
      for (int k = 0; k < 3; k++) begin
         p_e = 128'hfeedface_cafebabe_01234567_89abcdef ^ 128'(k);
         c_e = aes_model({iv_e, 32'(k + 2)}) ^ p_e;
         send_blk(p_e, 1'b0, k == 2);
         take_out(c_e, $sformatf("t4_out%0d", k));
         s_e = gf_mult(s_e ^ c_e, h_e);
      end
      s_e = gf_mult(s_e ^ {64'd128, 64'd384}, h_e);
      wait_done(s_e ^ aes_model({iv_e, 32'd1}), "t4_tag");
      for (int k = 0; k < 3; k++)
         check($sformatf("t4_icb%0d", k), icb_at(ib + k), {iv_e, 32'(k + 2)});

      // 5: AAD after payload is rejected and leaves the hash untouched
      gh_lat = 2; e0 = err_cnt;
      iv_e = 96'h0a0b0c0d_0e0f1011_12131415;
      do_start(iv_e, 1'b0, 1'b0);
      h_e = aes_model('0);
      a_e = 128'h11111111_22222222_33333333_44444444;
      send_blk(a_e, 1'b1, 1'b0);
      s_e = gf_mult(a_e, h_e);
      p_e = 128'h55555555_66666666_77777777_88888888;
      c_e = aes_model({iv_e, 32'd2}) ^ p_e;
      send_blk(p_e, 1'b0, 1'b0);
      take_out(c_e, "t5_out0");
      s_e = gf_mult(s_e ^ c_e, h_e);
      send_blk(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc, 1'b1, 1'b0);
      p_e = 128'hdddddddd_eeeeeeee_ffffffff_00000000;
      c_e = aes_model({iv_e, 32'd3}) ^ p_e;
      send_blk(p_e, 1'b0, 1'b1);
      take_out(c_e, "t5_out1");
      s_e = gf_mult(s_e ^ c_e, h_e);
      s_e = gf_mult(s_e ^ {64'd128, 64'd256}, h_e);
      wait_done(s_e ^ aes_model({iv_e, 32'd1}), "t5_tag");
      check("t5_err", 128'(err_cnt - e0), 128'd1);

      // 6: output stalled 20 cycles, then reset while in OUT_HASH
      iv_e = 96'h12345678_9abcdef0_0fedcba9;
      do_start(iv_e, 1'b0, 1'b0);
      p_e = 128'hdeadbeef_00000000_deadbeef_00000000;
      send_blk(p_e, 1'b0, 1'b1);
      begin
         int n = 0;
         @(negedge clk);
         while (!out_valid && n < TMO) begin @(negedge clk); n++; end
      end
      check("t6_out", out_blk, aes_model({iv_e, 32'd2}) ^ p_e);
      first_out = out_blk;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!out_valid || out_blk !== first_out) stable = 1'b0;
      end
      check("t6_stall_stable", 128'(stable), 128'd1);
      d0 = done_cnt;
      @(posedge clk); #1 reset_n = 1'b0;
      #1;
      check("t6_rst_ctl", 128'({busy, out_valid, in_ready, done, error, gctr_en, ghash_en, aes_start}), 128'd0);
      check("t6_rst_out_blk", out_blk, '0);
      check("t6_rst_tag", tag, '0);
      check("t6_rst_H", ghash_subkey_H, '0);
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_no_done", 128'(done_cnt - d0), 128'd0);

      // 7: fresh message after the abort
      gh_lat = 4;
      do_start(96'h0, 1'b0, 1'b0);
      send_blk(128'h0, 1'b0, 1'b1);
      take_out(128'h0388dace60b6a392f328c2b971b2fe78, "t7_out");
      wait_done(128'hab6e47d42cec13bdf53a67b21257bddf, "t7_tag");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
